// File: rtl/struct_packed_assembler_pkg.sv
// rtl/struct_packed_assembler_pkg.sv - shared entry/struct types and constants for the stream-to-struct packer
package struct_packed_assembler_pkg;

    typedef logic [2:0] test_array_entry_t;

    // Field order puts array_packed_packed in the low bits so slot j sits at bits [3j+2:3j].
    typedef struct packed {
        test_array_entry_t        vect_packed;
        test_array_entry_t [2:0]  vect_packed_packed;
        test_array_entry_t        array_packed;
        test_array_entry_t [2:0]  array_packed_packed;
    } struct_packed_t;

    localparam int ENTRY_W            = $bits(test_array_entry_t);
    localparam int ENTRIES_PER_STRUCT = $bits(struct_packed_t) / ENTRY_W;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } assembler_state_t;

endpackage

// File: rtl/struct_packed_assembler.sv
// rtl/struct_packed_assembler.sv - packs entry beats into a struct_packed_t frame held on a valid/ready output
module struct_packed_assembler
    import struct_packed_assembler_pkg::*;
#(
    parameter  int N_STRUCT = 3,
    localparam int TOTAL    = ENTRIES_PER_STRUCT * N_STRUCT,
    localparam int CNT_W    = $clog2(TOTAL + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ENTRY_W-1:0]           in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$bits(struct_packed_t)*N_STRUCT-1:0] out_data,
    output logic [CNT_W-1:0]             out_count,
    output logic                         out_partial
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    assembler_state_t                     state;
    assembler_state_t                     state_next;
    logic [CNT_W-1:0]                     count;
    logic [TOTAL-1:0][ENTRY_W-1:0]        buffer;
    logic                                 accept;
    logic                                 close;

    assign accept = in_valid && in_ready;
    // The closing beat is written but count is not advanced, so count stays <= TOTAL-1.
    assign close  = accept && ((count == LAST_IDX) || in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            count       <= '0;
            buffer      <= '0;
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_partial <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                FILL: begin
                    if (accept) begin
                        buffer[count] <= in_data;
                        if (close) begin
                            out_valid   <= 1'b1;
                            out_count   <= count + ONE;
                            out_partial <= in_last && (count < LAST_IDX);
                        end else begin
                            count <= count + ONE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        buffer    <= '0;
                        count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (close)     state_next = HOLD;
            HOLD:    if (out_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state == FILL);
    end

    assign out_data = buffer;

endmodule

// File: tb/tb_struct_packed_assembler.sv
// tb/tb_struct_packed_assembler.sv - randomized self-checking bench for struct_packed_assembler
module tb_struct_packed_assembler;
    import struct_packed_assembler_pkg::*;

    localparam int N_STRUCT = 3;
    localparam int TOTAL    = 8 * N_STRUCT;
    localparam int CNT_W    = $clog2(TOTAL + 1);
    localparam int FRAME_W  = 24 * N_STRUCT;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [FRAME_W-1:0]  out_data;
    logic [CNT_W-1:0]    out_count;
    logic                out_partial;

    int passed = 0;
    int total  = 0;

    logic [2:0] beats[$];
    struct_packed_t [N_STRUCT-1:0] view;

    always #5 clk = ~clk;

    struct_packed_assembler #(.N_STRUCT(N_STRUCT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_partial (out_partial)
    );

    // Reference: beat k lands in struct k/8 at slot k%8, three bits per slot, everything else zero.
    function automatic logic [FRAME_W-1:0] model_frame();
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < beats.size(); k++)
            f[24*(k/8) + 3*(k%8) +: 3] = beats[k];
        return f;
    endfunction

    task automatic drive_beat(input logic [2:0] d, input logic l, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        beats.push_back(d);
    endtask

    task automatic drive_frame(input int len, input logic use_last, input int max_gap);
        beats.delete();
        for (int k = 0; k < len; k++)
            drive_beat(3'($urandom_range(0, 7)), use_last && (k == len - 1), $urandom_range(0, max_gap));
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 3'd7; in_last = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else passed++;
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (out_count !== '0) $display("FAIL post_reset_out_count got=%0d exp=0", out_count); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); else passed++;
    endtask

    task automatic test_full_frame();
        beats.delete();
        out_ready = 1'b1;
        for (int k = 0; k < TOTAL; k++) begin
            drive_beat(3'(k % 8), 1'b0, 0);
            if (k == TOTAL - 2) begin
                total++; if (out_valid !== 1'b0) $display("FAIL full_early_valid got=%b exp=0", out_valid); else passed++;
            end
        end
        view = out_data;
        total++; if (out_valid !== 1'b1) $display("FAIL full_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_data !== model_frame()) $display("FAIL full_data got=%h exp=%h", out_data, model_frame()); else passed++;
        total++; if (out_count !== CNT_W'(TOTAL)) $display("FAIL full_count got=%0d exp=%0d", out_count, TOTAL); else passed++;
        total++; if (out_partial !== 1'b0) $display("FAIL full_partial got=%b exp=0", out_partial); else passed++;
        total++; if (view[0].array_packed_packed[0] !== 3'd0) $display("FAIL full_field_app0 got=%0d exp=0", view[0].array_packed_packed[0]); else passed++;
        total++; if (view[2].vect_packed !== 3'd7) $display("FAIL full_field_vp2 got=%0d exp=7", view[2].vect_packed); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL full_hold_in_ready got=%b exp=0", in_ready); else passed++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL full_consumed_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL full_consumed_in_ready got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_partial();
        beats.delete();
        for (int k = 0; k < 5; k++) drive_beat(3'd5, k == 4, 0);
        view = out_data;
        total++; if (out_valid !== 1'b1) $display("FAIL partial_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_count !== CNT_W'(5)) $display("FAIL partial_count got=%0d exp=5", out_count); else passed++;
        total++; if (out_partial !== 1'b1) $display("FAIL partial_flag got=%b exp=1", out_partial); else passed++;
        total++; if (out_data !== model_frame()) $display("FAIL partial_data got=%h exp=%h", out_data, model_frame()); else passed++;
        total++; if (view[0].array_packed_packed !== 9'o555) $display("FAIL partial_app got=%o exp=555", view[0].array_packed_packed); else passed++;
        total++; if (view[0].array_packed !== 3'd5) $display("FAIL partial_ap got=%0d exp=5", view[0].array_packed); else passed++;
        total++; if (view[0].vect_packed_packed !== 9'o005) $display("FAIL partial_vpp got=%o exp=005", view[0].vect_packed_packed); else passed++;
        total++; if (view[0].vect_packed !== 3'd0) $display("FAIL partial_vp got=%0d exp=0", view[0].vect_packed); else passed++;
        total++; if (out_data[FRAME_W-1:24] !== '0) $display("FAIL partial_upper got=%h exp=0", out_data[FRAME_W-1:24]); else passed++;
        release_frame();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_frame(TOTAL, 1'b0, 0);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_valid c=%0d got=%b exp=1", c, out_valid); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); else passed++;
            total++; if (out_data !== model_frame()) $display("FAIL bp_data c=%0d got=%h exp=%h", c, out_data, model_frame()); else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); else passed++;
        drive_frame(3, 1'b1, 0);
        total++; if (out_count !== CNT_W'(3)) $display("FAIL bp_next_count got=%0d exp=3", out_count); else passed++;
        total++; if (out_data !== model_frame()) $display("FAIL bp_next_data got=%h exp=%h", out_data, model_frame()); else passed++;
        release_frame();
    endtask

    task automatic test_reset_mid_frame();
        drive_frame(10, 1'b0, 1);
        rst_n = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid c=%0d got=%b exp=0", c, out_valid); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready c=%0d got=%b exp=0", c, in_ready); else passed++;
        end
        rst_n = 1'b1; in_valid = 1'b0;
        drive_frame(TOTAL, 1'b0, 0);
        total++; if (out_valid !== 1'b1) $display("FAIL midrst_next_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_data[2:0] !== beats[0]) $display("FAIL midrst_slot0 got=%0d exp=%0d", out_data[2:0], beats[0]); else passed++;
        total++; if (out_data !== model_frame()) $display("FAIL midrst_data got=%h exp=%h", out_data, model_frame()); else passed++;
        release_frame();
    endtask

    task automatic test_last_boundaries();
        drive_frame(1, 1'b1, 0);
        total++; if (out_count !== CNT_W'(1)) $display("FAIL last1_count got=%0d exp=1", out_count); else passed++;
        total++; if (out_partial !== 1'b1) $display("FAIL last1_partial got=%b exp=1", out_partial); else passed++;
        total++; if (out_data !== model_frame()) $display("FAIL last1_data got=%h exp=%h", out_data, model_frame()); else passed++;
        release_frame();
        drive_frame(TOTAL, 1'b1, 2);
        total++; if (out_count !== CNT_W'(TOTAL)) $display("FAIL last24_count got=%0d exp=%0d", out_count, TOTAL); else passed++;
        total++; if (out_partial !== 1'b0) $display("FAIL last24_partial got=%b exp=0", out_partial); else passed++;
        total++; if (out_data !== model_frame()) $display("FAIL last24_data got=%h exp=%h", out_data, model_frame()); else passed++;
        release_frame();
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 8; it++) begin
            int len;
            int hold;
            logic use_last;
            len      = $urandom_range(1, TOTAL);
            use_last = (len < TOTAL) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_frame(len, use_last, 2);
            total++; if (out_valid !== 1'b1) $display("FAIL rnd_valid it=%0d got=%b exp=1", it, out_valid); else passed++;
            total++; if (out_count !== CNT_W'(len)) $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, out_count, len); else passed++;
            total++; if (out_partial !== (len < TOTAL)) $display("FAIL rnd_partial it=%0d got=%b exp=%b", it, out_partial, len < TOTAL); else passed++;
            total++; if (out_data !== model_frame()) $display("FAIL rnd_data it=%0d got=%h exp=%h", it, out_data, model_frame()); else passed++;
            hold = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) begin
                in_valid = 1'b1;
                @(posedge clk); #1;
                total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL rnd_hold it=%0d ready=%b valid=%b exp=0/1", it, in_ready, out_valid); else passed++;
            end
            in_valid = 1'b0;
            release_frame();
            total++; if (out_valid !== 1'b0) $display("FAIL rnd_release it=%0d got=%b exp=0", it, out_valid); else passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_full_frame();
        test_partial();
        test_backpressure();
        test_reset_mid_frame();
        test_last_boundaries();
        test_random_frames();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
